// File: rtl/bus_trace_checker.sv
// rtl/bus_trace_checker.sv - delays expected vectors by LAT cycles and compares them against observed buses
// Optional: define BTC_STOP_ON_ERROR_EN to stop at DONE on the first mismatching cycle.
module bus_trace_checker #(
    parameter int W     = 64,
    parameter int CH    = 3,
    parameter int LAT   = 3,
    parameter int CNT_W = 16,
    parameter int IDX_W = 16,
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                finish,
    input  logic                exp_valid,
    input  logic [CH*W-1:0]     exp_data,
    input  logic [CH-1:0]       exp_care,
    input  logic [CH*W-1:0]     obs_data,
    output logic                busy,
    output logic                done,
    output logic                err_flag,
    output logic [CNT_W-1:0]    err_count,
    output logic [IDX_W-1:0]    entry_idx,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic [CH_W-1:0]     first_err_ch,
    output logic [W-1:0]        first_err_exp,
    output logic [W-1:0]        first_err_obs
);

    localparam int SUM_W = CNT_W + $clog2(CH + 1);
    localparam int DC_W  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [DC_W-1:0]    drain_cnt;

    logic               pv [LAT];
    logic [CH*W-1:0]    pd [LAT];
    logic [CH-1:0]      pc [LAT];
    logic [IDX_W-1:0]   pi [LAT];

    logic [CH-1:0]      mis;
    logic [SUM_W-1:0]   mis_cnt;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_next;
    logic [CH_W-1:0]    low_ch;
    logic [W-1:0]       low_exp;
    logic [W-1:0]       low_obs;
    logic               active;

    assign active = (state == S_RUN) || (state == S_DRAIN);

    // The tail of the delay line meets the bus values sampled on this edge.
    always_comb begin
        mis = '0;
        for (int c = 0; c < CH; c++) begin
            mis[c] = active && pv[LAT-1] && pc[LAT-1][c] &&
                     (pd[LAT-1][c*W +: W] != obs_data[c*W +: W]);
        end
        mis_cnt = '0;
        for (int c = 0; c < CH; c++) begin
            mis_cnt = mis_cnt + SUM_W'(mis[c]);
        end
        low_ch  = '0;
        low_exp = '0;
        low_obs = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (mis[c]) begin
                low_ch  = CH_W'(c);
                low_exp = pd[LAT-1][c*W +: W];
                low_obs = obs_data[c*W +: W];
            end
        end
        sum      = SUM_W'(err_count) + mis_cnt;
        cnt_next = (sum > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_flag      <= 1'b0;
            err_count     <= '0;
            entry_idx     <= '0;
            first_err_idx <= '0;
            first_err_ch  <= '0;
            first_err_exp <= '0;
            first_err_obs <= '0;
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
                pc[i] <= '0;
                pi[i] <= '0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
                pc[i] <= pc[i-1];
                pi[i] <= pi[i-1];
            end
            pv[0] <= (state == S_RUN) && exp_valid;
            pd[0] <= exp_data;
            pc[0] <= exp_care;
            pi[0] <= entry_idx;
            if ((state == S_RUN) && exp_valid) begin
                entry_idx <= entry_idx + IDX_W'(1);
            end

            if (|mis) begin
                err_count <= cnt_next;
                if (!err_flag) begin
                    err_flag      <= 1'b1;
                    first_err_idx <= pi[LAT-1];
                    first_err_ch  <= low_ch;
                    first_err_exp <= low_exp;
                    first_err_obs <= low_obs;
                end
            end

            case (state)
                S_RUN: begin
                    if (finish) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DC_W'(LAT - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end
                default: ;
            endcase

`ifdef BTC_STOP_ON_ERROR_EN
            if ((|mis) && !err_flag) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                for (int i = 0; i < LAT; i++) begin
                    pv[i] <= 1'b0;
                end
            end
`else
`endif

            // Restart overrides everything above, including a same-cycle finish.
            if (start) begin
                state         <= S_RUN;
                drain_cnt     <= '0;
                busy          <= 1'b1;
                done          <= 1'b0;
                err_flag      <= 1'b0;
                err_count     <= '0;
                entry_idx     <= '0;
                first_err_idx <= '0;
                first_err_ch  <= '0;
                first_err_exp <= '0;
                first_err_obs <= '0;
                for (int i = 0; i < LAT; i++) begin
                    pv[i] <= 1'b0;
                end
            end
        end
    end

endmodule
